// File: rtl/bus_arbiter.sv
// bus_arbiter: two-master round-robin arbiter with hold-time limit, muxing
// the granted master onto the shared bus port and returning read data to it.
module bus_arbiter #(
   parameter int unsigned MAX_HOLD = 16
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        m0_req,
   input  logic        m1_req,
   input  logic        m0_wr,
   input  logic        m1_wr,
   input  logic [15:0] m0_addr,
   input  logic [15:0] m1_addr,
   input  logic [63:0] m0_dout,
   input  logic [63:0] m1_dout,
   output logic        m0_grant,
   output logic        m1_grant,
   output logic [63:0] m0_din,
   output logic [63:0] m1_din,
   output logic        m_req,
   output logic        m_wr,
   output logic [15:0] m_addr,
   output logic [63:0] m_dout,
   input  logic [63:0] m_din
);

   localparam int unsigned CNT_W = 8;
   localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      G0   = 2'd1,
      G1   = 2'd2
   } state_t;

   state_t           state;
   state_t           state_nxt;
   logic             last;       // master served most recently; loses the next tie
   logic             last_nxt;
   logic [CNT_W-1:0] hold_cnt;
   logic [CNT_W-1:0] hold_nxt;

   // State, round-robin pointer and hold counter registers
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state    <= IDLE;
         last     <= 1'b1;
         hold_cnt <= '0;
      end else begin
         state    <= state_nxt;
         last     <= last_nxt;
         hold_cnt <= hold_nxt;
      end
   end

   // Arbitration: next state, pointer update and hold counting
   always_comb begin
      state_nxt = state;
      last_nxt  = last;
      hold_nxt  = hold_cnt;

      case (state)
         IDLE: begin
            if (m0_req && m1_req) begin
               state_nxt = last ? G0 : G1;
            end else if (m0_req) begin
               state_nxt = G0;
            end else if (m1_req) begin
               state_nxt = G1;
            end
         end
         G0: begin
            if (!m0_req) begin
               state_nxt = m1_req ? G1 : IDLE;
            end else if (m1_req && (hold_cnt == HOLD_LAST)) begin
               state_nxt = G1;
            end
         end
         G1: begin
            if (!m1_req) begin
               state_nxt = m0_req ? G0 : IDLE;
            end else if (m0_req && (hold_cnt == HOLD_LAST)) begin
               state_nxt = G0;
            end
         end
         default: state_nxt = IDLE;
      endcase

      // Counter restarts on any transition; otherwise it only runs while
      // the other master is waiting, so a lone master is never timed out.
      if (state_nxt != state) begin
         hold_nxt = '0;
         if (state_nxt == G0) begin
            last_nxt = 1'b0;
         end else if (state_nxt == G1) begin
            last_nxt = 1'b1;
         end
      end else if ((state == G0) && m1_req && (hold_cnt != HOLD_LAST)) begin
         hold_nxt = hold_cnt + CNT_W'(1);
      end else if ((state == G1) && m0_req && (hold_cnt != HOLD_LAST)) begin
         hold_nxt = hold_cnt + CNT_W'(1);
      end
   end

   // Grant decode and bus-side mux straight from the registered state
   always_comb begin
      m0_grant = 1'b0;
      m1_grant = 1'b0;
      m0_din   = '0;
      m1_din   = '0;
      m_req    = 1'b0;
      m_wr     = 1'b0;
      m_addr   = '0;
      m_dout   = '0;

      case (state)
         G0: begin
            m0_grant = 1'b1;
            m_req    = m0_req;
            m_wr     = m0_wr;
            m_addr   = m0_addr;
            m_dout   = m0_dout;
            m0_din   = m_din;
         end
         G1: begin
            m1_grant = 1'b1;
            m_req    = m1_req;
            m_wr     = m1_wr;
            m_addr   = m1_addr;
            m_dout   = m1_dout;
            m1_din   = m_din;
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_bus_arbiter.sv
// Scoreboard bench for bus_arbiter: stimulus queues expected outputs,
// a monitor pops and compares them at each falling clock edge.
module tb_bus_arbiter;

   logic        clk;
   logic        reset_n;
   logic        m0_req, m1_req, m0_wr, m1_wr;
   logic [15:0] m0_addr, m1_addr;
   logic [63:0] m0_dout, m1_dout;
   logic        m0_grant, m1_grant;
   logic [63:0] m0_din, m1_din;
   logic        m_req, m_wr;
   logic [15:0] m_addr;
   logic [63:0] m_dout, m_din;

   int total = 0;
   int bad   = 0;

   typedef struct {
      string        name;
      logic [211:0] v;
   } exp_t;

   exp_t sb[$];

   bus_arbiter #(.MAX_HOLD(16)) dut (
      .clk      (clk),
      .reset_n  (reset_n),
      .m0_req   (m0_req),
      .m1_req   (m1_req),
      .m0_wr    (m0_wr),
      .m1_wr    (m1_wr),
      .m0_addr  (m0_addr),
      .m1_addr  (m1_addr),
      .m0_dout  (m0_dout),
      .m1_dout  (m1_dout),
      .m0_grant (m0_grant),
      .m1_grant (m1_grant),
      .m0_din   (m0_din),
      .m1_din   (m1_din),
      .m_req    (m_req),
      .m_wr     (m_wr),
      .m_addr   (m_addr),
      .m_dout   (m_dout),
      .m_din    (m_din)
   );

   // Falling edges at 2,12,22..; rising edges at 7,17,27..
   initial begin
      clk = 1'b1;
      #2 clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic logic [211:0] pack(input logic g0, input logic g1,
                                         input logic rq, input logic wr,
                                         input logic [15:0] a, input logic [63:0] d,
                                         input logic [63:0] d0, input logic [63:0] d1);
      return {g0, g1, rq, wr, a, d, d0, d1};
   endfunction

   task automatic push(input string n, input logic [211:0] v);
      exp_t e;
      e.name = n;
      e.v    = v;
      sb.push_back(e);
   endtask

   task automatic exp_idle(input string n);
      push(n, pack(1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 64'd0, 64'd0, 64'd0));
   endtask

   // Expected view while master 0 owns the bus, from the bench's own drives
   task automatic exp_g0(input string n);
      push(n, pack(1'b1, 1'b0, m0_req, m0_wr, m0_addr, m0_dout, m_din, 64'd0));
   endtask

   task automatic exp_g1(input string n);
      push(n, pack(1'b0, 1'b1, m1_req, m1_wr, m1_addr, m1_dout, 64'd0, m_din));
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   // Monitor: compare one queued expectation per falling edge
   initial begin : monitor
      exp_t         e;
      logic [211:0] act;
      forever begin
         @(negedge clk);
         if (sb.size() > 0) begin
            e   = sb.pop_front();
            act = pack(m0_grant, m1_grant, m_req, m_wr, m_addr, m_dout, m0_din, m1_din);
            total++;
            if (act !== e.v) begin
               bad++;
               $display("FAIL %s: got g0g1rqwr=%b addr=%h dout=%h d0=%h d1=%h want g0g1rqwr=%b addr=%h dout=%h d0=%h d1=%h",
                        e.name, act[211:208], act[207:192], act[191:128], act[127:64], act[63:0],
                        e.v[211:208], e.v[207:192], e.v[191:128], e.v[127:64], e.v[63:0]);
            end
         end
      end
   end

   initial begin : watchdog
      #100000;
      $display("FAIL watchdog: got=timeout want=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin : stim
      reset_n = 1'b0;
      m0_req  = 1'b1;
      m1_req  = 1'b1;
      m0_wr   = 1'b1;
      m1_wr   = 1'b0;
      m0_addr = 16'h00DF;
      m1_addr = 16'h7000;
      m0_dout = 64'd7;
      m1_dout = 64'h00000000000000A5;
      m_din   = 64'd0;
      exp_idle("reset");
      #3 reset_n = 1'b1;

      // Master 0 wins the first tie and writes through
      cyc();
      m_din = 64'd126;
      push("m0_first", pack(1'b1, 1'b0, 1'b1, 1'b1, 16'h00DF, 64'd7, 64'd126, 64'd0));
      for (int i = 1; i < 16; i++) begin
         cyc();
         exp_g0($sformatf("m0_hold%0d", i));
      end

      // Preempted after exactly 16 cycles
      cyc();
      push("m1_preempt", pack(1'b0, 1'b1, 1'b1, 1'b0, 16'h7000, 64'hA5, 64'd0, 64'd126));
      for (int i = 1; i < 16; i++) begin
         cyc();
         exp_g1($sformatf("m1_hold%0d", i));
      end
      cyc();
      push("m0_back", pack(1'b1, 1'b0, 1'b1, 1'b1, 16'h00DF, 64'd7, 64'd126, 64'd0));

      // Release with other request pending: direct handover, no idle bubble
      cyc();
      m0_req  = 1'b0;
      m1_addr = 16'h71FF;
      push("m0_release", pack(1'b1, 1'b0, 1'b0, 1'b1, 16'h00DF, 64'd7, 64'd126, 64'd0));
      cyc();
      push("handover", pack(1'b0, 1'b1, 1'b1, 1'b0, 16'h71FF, 64'hA5, 64'd0, 64'd126));

      // Lone master keeps the bus indefinitely
      for (int i = 0; i < 40; i++) begin
         cyc();
         exp_g1($sformatf("lone%0d", i));
      end

      // Release to idle, then tie goes to master 0 (master 1 was last)
      cyc();
      m1_req = 1'b0;
      push("m1_release", pack(1'b0, 1'b1, 1'b0, 1'b0, 16'h71FF, 64'hA5, 64'd0, 64'd126));
      cyc();
      exp_idle("idle");
      cyc();
      m0_req = 1'b1;
      m1_req = 1'b1;
      exp_idle("idle_raise");
      cyc();
      push("tie_m0", pack(1'b1, 1'b0, 1'b1, 1'b1, 16'h00DF, 64'd7, 64'd126, 64'd0));
      cyc();
      exp_g0("g0_again");

      // Asynchronous reset mid-grant drops outputs before the next edge
      cyc();
      reset_n = 1'b0;
      exp_idle("async_reset");
      cyc();
      reset_n = 1'b1;
      exp_idle("post_release");
      cyc();
      push("restart_m0", pack(1'b1, 1'b0, 1'b1, 1'b1, 16'h00DF, 64'd7, 64'd126, 64'd0));

      cyc();
      cyc();
      total++;
      if (sb.size() != 0) begin
         bad++;
         $display("FAIL drain: got=%0d pending want=0", sb.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
